match_sequencer: RTL and testbench
==================================

# match_sequencer

Top-level game-flow controller for the pitch. It sequences the ball datapath through serve, play, goal and game-over phases, and generates the shared movement tick. It detects goals from the ball position and keeps both team scores. It drives `game_on`/`game_over` into the ball controller and the score/state outputs to the VGA overlay.

## Interface
- `BALL_RADIUS`, 8: ball radius in px.
- `GOAL_RADIUS`, 30: goal ring radius in px.
- `MOVEMENT_FREQUENCY`, 200000: clock cycles per movement tick.
- `SERVE_TICKS`, 120: movement ticks spent in SERVE before play.
- `GOAL_HOLD_TICKS`, 60: movement ticks the GOAL state is held.
- `WIN_SCORE`, 5: score that ends the match (1..15).

Ports:
- `clk`, in, 1: pixel/system clock.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: level, debounced start button.
- `ball_x`, in, 10: ball centre x (px).
- `ball_y`, in, 10: ball centre y (px).
- `game_on`, out, 1: ball may move.
- `game_over`, out, 1: match finished.
- `ball_serve`, out, 1: one-cycle pulse; ball controller recentres to (463,275).
- `move_tick`, out, 1: one-cycle strobe every `MOVEMENT_FREQUENCY` cycles.
- `score1`, out, 4: team 1 score.
- `score2`, out, 4: team 2 score.
- `winner`, out, 2: 0 none, 1 team 1, 2 team 2.
- `phase`, out, 3: current state encoding.

## Operation
- States: IDLE=0, SERVE=1, PLAY=2, GOAL=3, OVER=4.
- IDLE: `start`=1 → SERVE. Scores are already 0.
- SERVE:
  - Assert `ball_serve` in the entry cycle.
  - Count `SERVE_TICKS` move ticks, then → PLAY.
- PLAY: `game_on`=1. Goal hit → GOAL.
- GOAL:
  - Increment the scoring team once, on entry.
  - Hold `GOAL_HOLD_TICKS` ticks.
  - Then → OVER if either score == `WIN_SCORE`, else → SERVE.
- OVER:
  - `game_over`=1 and `winner` set.
  - A rising edge of `start` clears scores and `winner` → IDLE.
- Goal geometry:
  - Team-2 goals (scored by team 1) are centred at y=450, x∈{300,400,500}.
  - Team-1 goals (scored by team 2) are centred at y=100, same x values.
  - A hit means dx²+dy² < (GOAL_RADIUS−BALL_RADIUS)².
- Arithmetic:
  - dx and dy are 11-bit signed differences; squares are 20-bit unsigned.
  - The sum is 21-bit unsigned. No wrap is permitted.
- Hits are evaluated only in PLAY. If both teams hit in the same cycle, team 1 wins priority.
- `start` is ignored outside IDLE and OVER. A level held high from OVER does not restart; a fresh rising edge is required.
- Scores saturate at `WIN_SCORE`.
- The move-tick divider free-runs in every state, including OVER.

## Timing
- Reset values:
  - state IDLE.
  - `game_on`, `game_over`, `ball_serve`, `move_tick` = 0.
  - Scores 0, `winner` 0, divider 0.
- `move_tick`:
  - High in the cycle the divider equals `MOVEMENT_FREQUENCY`−1; the divider returns to 0 the next cycle.
  - First tick after reset lands at cycle `MOVEMENT_FREQUENCY`.
- Goal detect is registered, 1-cycle latency. The state leaves PLAY 2 cycles after the ball position enters a goal.
- All outputs are registered. `game_on` drops in the same cycle `phase` becomes GOAL.
- SERVE/GOAL counters count only on `move_tick` cycles. A tick in the entry cycle counts.
- `reset` asserted mid-match returns everything to reset values on the next edge, with no score retained.

## Structure
- Shared package `game_pkg`:
  - State enum.
  - Goal centre constants (y 100/450, x 300/400/500).
  - Ball serve position (463,275).
- Sub-module `goal_detector` (parameters `BALL_RADIUS`, `GOAL_RADIUS`):
  - Inputs: ball x/y.
  - Outputs: registered `hit_team1_goal`, `hit_team2_goal`.
  - The ball controller may later share it.

## Test plan
Sim parameters: `MOVEMENT_FREQUENCY`=4, `SERVE_TICKS`=2, `GOAL_HOLD_TICKS`=2, `WIN_SCORE`=2.
- Reset, idle 20 cycles → `move_tick` high at cycles 4, 8, 12…; all other outputs 0, `phase`=0.
- Start pulse, ball at (463,275) → one `ball_serve` pulse; `phase`=1, then `phase`=2 after 2 ticks, `game_on`=1.
- In PLAY, drive ball to (400,450) → `score1`=1, `phase`=3 two cycles later, `game_on`=0; back to SERVE after 2 ticks.
- Ball at (400+22,450), distance 22 = limit → no goal; at (421,450) → goal.
- Two team-2 goals via (300,100) → `score2`=2, `phase`=4, `game_over`=1, `winner`=2. `start` held high → stays OVER; release then press → IDLE, scores 0.
- Assert `reset` during GOAL with `score1`=1 → next cycle all outputs at reset values, `phase`=0.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the pitch game-flow logic: state encoding, goal centres
// and the ball serve position.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_GOAL  = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    // Team-1 goals sit at the top of the pitch, team-2 goals at the bottom.
    localparam int GOAL_Y_TEAM1  = 100;
    localparam int GOAL_Y_TEAM2  = 450;
    localparam int GOAL_X_LEFT   = 300;
    localparam int GOAL_X_MID    = 400;
    localparam int GOAL_X_RIGHT  = 500;

    localparam int SERVE_X       = 463;
    localparam int SERVE_Y       = 275;

    localparam logic [1:0] WIN_NONE  = 2'd0;
    localparam logic [1:0] WIN_TEAM1 = 2'd1;
    localparam logic [1:0] WIN_TEAM2 = 2'd2;

endpackage

// File: rtl/goal_detector.sv
// Registered ball-in-goal detection against the three goal rings of each team.
// A hit is a strict inside test: dx^2 + dy^2 < (GOAL_RADIUS - BALL_RADIUS)^2.
module goal_detector
    import game_pkg::*;
#(
    parameter int BALL_RADIUS = 8,
    parameter int GOAL_RADIUS = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] ball_x,
    input  logic [9:0] ball_y,
    output logic       hit_team1_goal,
    output logic       hit_team2_goal
);

    localparam logic [20:0] LIMIT_SQ =
        21'((GOAL_RADIUS - BALL_RADIUS) * (GOAL_RADIUS - BALL_RADIUS));

    logic near_team1_p0;
    logic near_team2_p0;

    function automatic logic signed [10:0] diff(input logic [9:0] p, input int c);
        logic signed [10:0] cs;
        cs = 11'(c);
        return $signed({1'b0, p}) - cs;
    endfunction

    // Squaring the magnitude keeps the product unsigned and within 20 bits.
    function automatic logic [19:0] square(input logic signed [10:0] d);
        logic signed [10:0] neg;
        logic [9:0]         mag;
        neg = -d;
        mag = d[10] ? neg[9:0] : d[9:0];
        return {10'b0, mag} * {10'b0, mag};
    endfunction

    function automatic logic in_ring(input logic [9:0] x, input logic [9:0] y,
                                     input int cx, input int cy);
        logic [20:0] dist_sq;
        dist_sq = {1'b0, square(diff(x, cx))} + {1'b0, square(diff(y, cy))};
        return dist_sq < LIMIT_SQ;
    endfunction

    function automatic logic near_row(input logic [9:0] x, input logic [9:0] y,
                                      input int cy);
        return in_ring(x, y, GOAL_X_LEFT, cy) |
               in_ring(x, y, GOAL_X_MID, cy)  |
               in_ring(x, y, GOAL_X_RIGHT, cy);
    endfunction

    always_comb begin
        near_team1_p0 = near_row(ball_x, ball_y, GOAL_Y_TEAM1);
        near_team2_p0 = near_row(ball_x, ball_y, GOAL_Y_TEAM2);
    end

    // p0 -> p1: geometry result registered
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_team1_goal <= 1'b0;
            hit_team2_goal <= 1'b0;
        end else begin
            hit_team1_goal <= near_team1_p0;
            hit_team2_goal <= near_team2_p0;
        end
    end

endmodule

// File: rtl/match_sequencer.sv
// Game-flow controller: IDLE -> SERVE -> PLAY -> GOAL -> (SERVE | OVER), with the
// free-running movement tick, goal scoring and registered status outputs.
module match_sequencer
    import game_pkg::*;
#(
    parameter int BALL_RADIUS        = 8,
    parameter int GOAL_RADIUS        = 30,
    parameter int MOVEMENT_FREQUENCY = 200000,
    parameter int SERVE_TICKS        = 120,
    parameter int GOAL_HOLD_TICKS    = 60,
    parameter int WIN_SCORE          = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [9:0] ball_x,
    input  logic [9:0] ball_y,
    output logic       game_on,
    output logic       game_over,
    output logic       ball_serve,
    output logic       move_tick,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [1:0] winner,
    output logic [2:0] phase
);

    localparam int DIV_W     = (MOVEMENT_FREQUENCY > 2) ? $clog2(MOVEMENT_FREQUENCY) : 1;
    localparam int MAX_TICKS = (SERVE_TICKS > GOAL_HOLD_TICKS) ? SERVE_TICKS : GOAL_HOLD_TICKS;
    localparam int CNT_W     = $clog2(MAX_TICKS + 1);

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(MOVEMENT_FREQUENCY - 1);
    localparam logic [DIV_W-1:0] DIV_PRE    = DIV_W'(MOVEMENT_FREQUENCY - 2);
    localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_TICKS - 1);
    localparam logic [CNT_W-1:0] GOAL_LAST  = CNT_W'(GOAL_HOLD_TICKS - 1);
    localparam logic [3:0]       WIN        = 4'(WIN_SCORE);

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q;
    logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [3:0]       score1_d, score2_d;
    logic [1:0]       winner_d;
    logic             start_q;
    logic             start_rise;
    logic             hit_team1_goal, hit_team2_goal;

    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s >= WIN) ? WIN : s + 4'd1;
    endfunction

    goal_detector #(
        .BALL_RADIUS (BALL_RADIUS),
        .GOAL_RADIUS (GOAL_RADIUS)
    ) u_goal_detector (
        .clk            (clk),
        .reset          (reset),
        .ball_x         (ball_x),
        .ball_y         (ball_y),
        .hit_team1_goal (hit_team1_goal),
        .hit_team2_goal (hit_team2_goal)
    );

    // move_tick is registered one count early so it is high while div_q is at its last value.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q     <= '0;
            move_tick <= 1'b0;
        end else begin
            div_q     <= (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
            move_tick <= (div_q == DIV_PRE);
        end
    end

    assign start_rise = start & ~start_q;
    assign phase      = state_q;

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = '0;
        score1_d   = score1;
        score2_d   = score2;
        winner_d   = winner;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_SERVE;
            end
            ST_SERVE: begin
                tick_cnt_d = move_tick ? tick_cnt_q + CNT_W'(1) : tick_cnt_q;
                if (move_tick && tick_cnt_q == SERVE_LAST) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                // Team 1 scores into the team-2 goals and takes priority.
                if (hit_team2_goal) begin
                    state_d  = ST_GOAL;
                    score1_d = sat_inc(score1);
                end else if (hit_team1_goal) begin
                    state_d  = ST_GOAL;
                    score2_d = sat_inc(score2);
                end
            end
            ST_GOAL: begin
                tick_cnt_d = move_tick ? tick_cnt_q + CNT_W'(1) : tick_cnt_q;
                if (move_tick && tick_cnt_q == GOAL_LAST) begin
                    if (score1 == WIN || score2 == WIN) begin
                        state_d  = ST_OVER;
                        winner_d = (score1 == WIN) ? WIN_TEAM1 : WIN_TEAM2;
                    end else begin
                        state_d = ST_SERVE;
                    end
                end
            end
            ST_OVER: begin
                if (start_rise) begin
                    state_d  = ST_IDLE;
                    score1_d = 4'd0;
                    score2_d = 4'd0;
                    winner_d = WIN_NONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_d != state_q) tick_cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            score1     <= 4'd0;
            score2     <= 4'd0;
            winner     <= WIN_NONE;
            start_q    <= 1'b0;
            game_on    <= 1'b0;
            game_over  <= 1'b0;
            ball_serve <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            score1     <= score1_d;
            score2     <= score2_d;
            winner     <= winner_d;
            start_q    <= start;
            game_on    <= (state_d == ST_PLAY);
            game_over  <= (state_d == ST_OVER);
            ball_serve <= (state_d == ST_SERVE) && (state_q != ST_SERVE);
        end
    end

endmodule

// File: tb/tb_match_sequencer.sv
// Directed bench for match_sequencer with a short tick period (4 cycles), short
// serve/goal holds (2 ticks) and a winning score of 2.
module tb_match_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic       game_on, game_over, ball_serve, move_tick;
    logic [3:0] score1, score2;
    logic [1:0] winner;
    logic [2:0] phase;
    logic [15:0] obs;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int exp_cyc  = 0;

    always #5 clk = ~clk;

    match_sequencer #(
        .BALL_RADIUS        (8),
        .GOAL_RADIUS        (30),
        .MOVEMENT_FREQUENCY (4),
        .SERVE_TICKS        (2),
        .GOAL_HOLD_TICKS    (2),
        .WIN_SCORE          (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .game_on    (game_on),
        .game_over  (game_over),
        .ball_serve (ball_serve),
        .move_tick  (move_tick),
        .score1     (score1),
        .score2     (score2),
        .winner     (winner),
        .phase      (phase)
    );

    assign obs = {game_on, game_over, ball_serve, phase, score1, score2, winner};

    // Expected status vector: {game_on, game_over, ball_serve, phase, score1, score2, winner}
    function automatic logic [15:0] st(input bit on, input bit ov, input bit sv, input int ph,
                                       input int s1, input int s2, input int w);
        return {on, ov, sv, 3'(ph), 4'(s1), 4'(s2), 2'(w)};
    endfunction

    // Cycle on which the next phase becomes visible after holding for n ticks,
    // where cycle numbers with c % 4 == 0 carry a move tick.
    function automatic int exit_cycle(input int entry, input int n);
        int c;
        int k;
        c = entry;
        k = 0;
        for (int i = 0; i < 1000; i++) begin
            if (c % 4 == 0) k++;
            if (k == n) return c + 1;
            c++;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_ball(input int x, input int y);
        ball_x = 10'(x);
        ball_y = 10'(y);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        set_ball(463, 275);
        step();
        step();
        reset = 1'b0;
        cyc   = 1;
        checks++;
        if (obs !== st(0, 0, 0, 0, 0, 0, 0) || move_tick !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got=%h/%b exp=%h/0", obs, move_tick, st(0, 0, 0, 0, 0, 0, 0));
        end
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (move_tick !== (cyc % 4 == 0)) begin
                failures++;
                $display("FAIL idle_tick cyc=%0d got=%b exp=%b", cyc, move_tick, (cyc % 4 == 0));
            end
            checks++;
            if (obs !== st(0, 0, 0, 0, 0, 0, 0)) begin
                failures++;
                $display("FAIL idle_outputs cyc=%0d got=%h exp=%h", cyc, obs, st(0, 0, 0, 0, 0, 0, 0));
            end
        end
    endtask

    task automatic test_start_serve();
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (obs !== st(0, 0, 1, 1, 0, 0, 0)) begin
            failures++;
            $display("FAIL serve_entry cyc=%0d got=%h exp=%h", cyc, obs, st(0, 0, 1, 1, 0, 0, 0));
        end
        exp_cyc = exit_cycle(cyc, 2);
        while (cyc < exp_cyc) begin
            step();
            checks++;
            if (cyc < exp_cyc) begin
                if (obs !== st(0, 0, 0, 1, 0, 0, 0)) begin
                    failures++;
                    $display("FAIL serve_hold cyc=%0d got=%h exp=%h", cyc, obs, st(0, 0, 0, 1, 0, 0, 0));
                end
            end else if (obs !== st(1, 0, 0, 2, 0, 0, 0)) begin
                failures++;
                $display("FAIL play_entry cyc=%0d got=%h exp=%h", cyc, obs, st(1, 0, 0, 2, 0, 0, 0));
            end
        end
    endtask

    task automatic test_goal_boundary();
        set_ball(422, 450);
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (obs !== st(1, 0, 0, 2, 0, 0, 0)) begin
                failures++;
                $display("FAIL edge_x22 cyc=%0d got=%h exp=%h", cyc, obs, st(1, 0, 0, 2, 0, 0, 0));
            end
        end
        set_ball(300, 122);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs !== st(1, 0, 0, 2, 0, 0, 0)) begin
                failures++;
                $display("FAIL edge_y22 cyc=%0d got=%h exp=%h", cyc, obs, st(1, 0, 0, 2, 0, 0, 0));
            end
        end
        set_ball(421, 450);
        step();
        checks++;
        if (obs !== st(1, 0, 0, 2, 0, 0, 0)) begin
            failures++;
            $display("FAIL goal_latency cyc=%0d got=%h exp=%h", cyc, obs, st(1, 0, 0, 2, 0, 0, 0));
        end
        step();
        checks++;
        if (obs !== st(0, 0, 0, 3, 1, 0, 0)) begin
            failures++;
            $display("FAIL goal_team1 cyc=%0d got=%h exp=%h", cyc, obs, st(0, 0, 0, 3, 1, 0, 0));
        end
        // Ball stays inside the goal through GOAL and SERVE: no further scoring.
        exp_cyc = exit_cycle(cyc, 2);
        while (cyc < exp_cyc) begin
            step();
            checks++;
            if (cyc < exp_cyc) begin
                if (obs !== st(0, 0, 0, 3, 1, 0, 0)) begin
                    failures++;
                    $display("FAIL goal_hold cyc=%0d got=%h exp=%h", cyc, obs, st(0, 0, 0, 3, 1, 0, 0));
                end
            end else if (obs !== st(0, 0, 1, 1, 1, 0, 0)) begin
                failures++;
                $display("FAIL reserve cyc=%0d got=%h exp=%h", cyc, obs, st(0, 0, 1, 1, 1, 0, 0));
            end
        end
        exp_cyc = exit_cycle(cyc, 2);
        while (cyc < exp_cyc) begin
            step();
            checks++;
            if (cyc < exp_cyc) begin
                if (obs !== st(0, 0, 0, 1, 1, 0, 0)) begin
                    failures++;
                    $display("FAIL reserve_hold cyc=%0d got=%h exp=%h", cyc, obs, st(0, 0, 0, 1, 1, 0, 0));
                end
                if (cyc == exp_cyc - 1) set_ball(463, 275);
            end else if (obs !== st(1, 0, 0, 2, 1, 0, 0)) begin
                failures++;
                $display("FAIL replay cyc=%0d got=%h exp=%h", cyc, obs, st(1, 0, 0, 2, 1, 0, 0));
            end
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs !== st(1, 0, 0, 2, 1, 0, 0)) begin
                failures++;
                $display("FAIL replay_steady cyc=%0d got=%h exp=%h", cyc, obs, st(1, 0, 0, 2, 1, 0, 0));
            end
        end
    endtask

    task automatic test_team2_win();
        set_ball(300, 100);
        step();
        step();
        checks++;
        if (obs !== st(0, 0, 0, 3, 1, 1, 0)) begin
            failures++;
            $display("FAIL goal_team2_a cyc=%0d got=%h exp=%h", cyc, obs, st(0, 0, 0, 3, 1, 1, 0));
        end
        set_ball(463, 275);
        exp_cyc = exit_cycle(cyc, 2);
        while (cyc < exp_cyc) step();
        checks++;
        if (obs !== st(0, 0, 1, 1, 1, 1, 0)) begin
            failures++;
            $display("FAIL serve_after_a cyc=%0d got=%h exp=%h", cyc, obs, st(0, 0, 1, 1, 1, 1, 0));
        end
        exp_cyc = exit_cycle(cyc, 2);
        while (cyc < exp_cyc) step();
        checks++;
        if (obs !== st(1, 0, 0, 2, 1, 1, 0)) begin
            failures++;
            $display("FAIL play_after_a cyc=%0d got=%h exp=%h", cyc, obs, st(1, 0, 0, 2, 1, 1, 0));
        end
        set_ball(500, 79);
        step();
        step();
        checks++;
        if (obs !== st(0, 0, 0, 3, 1, 2, 0)) begin
            failures++;
            $display("FAIL goal_team2_b cyc=%0d got=%h exp=%h", cyc, obs, st(0, 0, 0, 3, 1, 2, 0));
        end
        // start rises while in GOAL (ignored) and is still high on reaching OVER.
        start = 1'b1;
        set_ball(463, 275);
        exp_cyc = exit_cycle(cyc, 2);
        while (cyc < exp_cyc) begin
            step();
            checks++;
            if (cyc < exp_cyc) begin
                if (obs !== st(0, 0, 0, 3, 1, 2, 0)) begin
                    failures++;
                    $display("FAIL goal_b_hold cyc=%0d got=%h exp=%h", cyc, obs, st(0, 0, 0, 3, 1, 2, 0));
                end
            end else if (obs !== st(0, 1, 0, 4, 1, 2, 2)) begin
                failures++;
                $display("FAIL over_entry cyc=%0d got=%h exp=%h", cyc, obs, st(0, 1, 0, 4, 1, 2, 2));
            end
        end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (obs !== st(0, 1, 0, 4, 1, 2, 2)) begin
                failures++;
                $display("FAIL over_held_start cyc=%0d got=%h exp=%h", cyc, obs, st(0, 1, 0, 4, 1, 2, 2));
            end
        end
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (obs !== st(0, 1, 0, 4, 1, 2, 2)) begin
                failures++;
                $display("FAIL over_released cyc=%0d got=%h exp=%h", cyc, obs, st(0, 1, 0, 4, 1, 2, 2));
            end
        end
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (obs !== st(0, 0, 0, 0, 0, 0, 0)) begin
            failures++;
            $display("FAIL restart_idle cyc=%0d got=%h exp=%h", cyc, obs, st(0, 0, 0, 0, 0, 0, 0));
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs !== st(0, 0, 0, 0, 0, 0, 0)) begin
                failures++;
                $display("FAIL idle_stays cyc=%0d got=%h exp=%h", cyc, obs, st(0, 0, 0, 0, 0, 0, 0));
            end
        end
    endtask

    task automatic test_reset_mid_goal();
        start = 1'b1;
        step();
        start = 1'b0;
        exp_cyc = exit_cycle(cyc, 2);
        while (cyc < exp_cyc) step();
        set_ball(400, 450);
        step();
        step();
        checks++;
        if (obs !== st(0, 0, 0, 3, 1, 0, 0)) begin
            failures++;
            $display("FAIL goal_mid400 cyc=%0d got=%h exp=%h", cyc, obs, st(0, 0, 0, 3, 1, 0, 0));
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        cyc   = 1;
        checks++;
        if (obs !== st(0, 0, 0, 0, 0, 0, 0) || move_tick !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid got=%h/%b exp=%h/0", obs, move_tick, st(0, 0, 0, 0, 0, 0, 0));
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (move_tick !== (cyc % 4 == 0)) begin
                failures++;
                $display("FAIL tick_after_reset cyc=%0d got=%b exp=%b", cyc, move_tick, (cyc % 4 == 0));
            end
            checks++;
            if (obs !== st(0, 0, 0, 0, 0, 0, 0)) begin
                failures++;
                $display("FAIL idle_after_reset cyc=%0d got=%h exp=%h", cyc, obs, st(0, 0, 0, 0, 0, 0, 0));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_start_serve();
        test_goal_boundary();
        test_team2_win();
        test_reset_mid_goal();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
